wb_port_arbiter: RTL

- Shares the single register-file write port between two sources:
  - the in-order pipeline writeback from the MEM/WB stage;
  - out-of-band late results from long-latency units (divider, cache refill).
- Late results are buffered in a small FIFO and given the port on idle pipeline cycles, or forcibly via a starvation limit.
- When forced, the arbiter stalls the pipeline.
- Sits between the MEM/WB pipeline register and the register file write port.

---
 rtl/wb_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between MEM/WB writeback and a late-result queue
module wb_port_arbiter #(
  parameter int DATA_W     = 64,
  parameter int REG_IDX_W  = 5,
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pipe_reg_write,
  input  logic [REG_IDX_W-1:0]        pipe_rd,
  input  logic [DATA_W-1:0]           pipe_data,
  output logic                        pipe_stall,
  input  logic                        late_valid,
  output logic                        late_ready,
  input  logic [REG_IDX_W-1:0]        late_rd,
  input  logic [DATA_W-1:0]           late_data,
  output logic                        rf_we,
  output logic [REG_IDX_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  // Late-queue storage; contents need no reset because occupancy gates every use.
  logic [REG_IDX_W-1:0] lq_rd   [LQ_DEPTH];
  logic [DATA_W-1:0]    lq_data [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]  lq_kill;
  logic [LQ_DEPTH-1:0]  entry_valid;
  logic [LQ_DEPTH-1:0]  kill_hit;

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [STV_W-1:0]     starve_cnt;

  logic q_nonempty;
  logic q_full;
  logic force_q;
  logic pipe_win;
  logic q_grant;
  logic lq_push;
  logic pipe_kills;

  assign q_nonempty = (lq_count != '0);
  assign q_full     = (lq_count == CNT_W'(LQ_DEPTH));

  // late_ready depends on registered occupancy only, never on a same-cycle dequeue.
  assign late_ready = !q_full;

  // A late result to x0 completes its handshake but is never stored.
  assign lq_push    = late_valid && late_ready && (late_rd != '0);

  assign force_q    = q_nonempty && ((starve_cnt == STV_W'(STARVE_MAX)) || q_full);
  assign pipe_win   = pipe_reg_write && !force_q;
  assign q_grant    = q_nonempty && !pipe_win;
  assign pipe_stall = pipe_reg_write && force_q;
  assign pipe_kills = pipe_win && (pipe_rd != '0);

  // Per-slot occupancy and WAW match against the winning pipeline write.
  for (genvar g = 0; g < LQ_DEPTH; g++) begin : g_ent
    logic [PTR_W-1:0] off;
    assign off            = PTR_W'(g) - rd_ptr;
    assign entry_valid[g] = ({1'b0, off} < lq_count);
    assign kill_hit[g]    = pipe_kills && entry_valid[g] && (lq_rd[g] == pipe_rd);
  end

  // Capture accepted late results into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (lq_push) begin
      lq_rd[wr_ptr]   <= late_rd;
      lq_data[wr_ptr] <= late_data;
    end
  end

  // Kill flags: older entries shadowed by a pipe write are marked; a fresh entry starts live.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lq_kill <= '0;
    end else begin
      lq_kill <= lq_kill | kill_hit;
      if (lq_push) begin
        lq_kill[wr_ptr] <= 1'b0;
      end
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lq_count <= '0;
    end else begin
      if (lq_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (q_grant) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      lq_count <= lq_count + CNT_W'(lq_push) - CNT_W'(q_grant);
    end
  end

  // Starvation counter: counts denied cycles of a nonempty queue, saturating at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!q_nonempty || q_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STV_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered write port: the winner lands one cycle after grant; x0 and killed entries write nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (pipe_win) begin
      rf_we    <= (pipe_rd != '0);
      rf_waddr <= pipe_rd;
      rf_wdata <= pipe_data;
    end else if (q_grant) begin
      rf_we    <= !lq_kill[rd_ptr] && (lq_rd[rd_ptr] != '0);
      rf_waddr <= lq_rd[rd_ptr];
      rf_wdata <= lq_data[rd_ptr];
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule
